// File: rtl/enc_pkg.sv
// Shared definitions for the mux-tree encoder: default width, index type and
// a constant-foldable log2 helper for tools lacking $clog2.
package enc_pkg;

    parameter int N_DEFAULT = 8;

    typedef logic [2:0] enc_idx_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/enc_mux_node.sv
// One 2:1 merge node of the encoder tree: the upper half wins when present and
// its presence becomes index bit LVL; both halves present flags multi-hot.
module enc_mux_node #(
    parameter int W   = 3,
    parameter int LVL = 0
) (
    input  logic         lo_p,
    input  logic         hi_p,
    input  logic [W-1:0] lo_ix,
    input  logic [W-1:0] hi_ix,
    input  logic         lo_m,
    input  logic         hi_m,
    output logic         p_o,
    output logic [W-1:0] ix_o,
    output logic         m_o
);

    // Partial indices only populate bits below LVL, so OR-ing in the select
    // bit at LVL widens the index by one without disturbing the lower bits.
    logic [W-1:0] sel_bit;

    always_comb begin
        sel_bit = {{(W-1){1'b0}}, hi_p} << LVL;
        p_o     = lo_p | hi_p;
        ix_o    = (hi_p ? hi_ix : lo_ix) | sel_bit;
        m_o     = lo_m | hi_m | (lo_p & hi_p);
    end

endmodule

// File: rtl/encoder_using_mux_design.sv
// N-to-log2(N) highest-set-bit encoder built as a 2:1 mux tree, with valid and
// multi-hot flags and a single registered output stage.
module encoder_using_mux_design
    import enc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        d,
    output logic [clog2(N)-1:0] y,
    output logic                valid,
    output logic                multi
);

    localparam int W = clog2(N);

    logic [W-1:0] y_d, y_q;
    logic         valid_d, valid_q;
    logic         multi_d, multi_q;

    // Level lv holds N>>lv (present, index, multi) tuples; level 0 is the raw input.
    for (genvar lv = 0; lv <= W; lv++) begin : g_lvl
        logic [(N>>lv)-1:0]        p;
        logic [(N>>lv)-1:0]        m;
        logic [(N>>lv)-1:0][W-1:0] ix;

        if (lv == 0) begin : g_leaf
            always_comb begin
                p  = d;
                m  = '0;
                ix = '0;
            end
        end else begin : g_node
            for (genvar k = 0; k < (N >> lv); k++) begin : g_n
                enc_mux_node #(
                    .W   (W),
                    .LVL (lv - 1)
                ) u_node (
                    .lo_p  (g_lvl[lv-1].p[2*k]),
                    .hi_p  (g_lvl[lv-1].p[2*k+1]),
                    .lo_ix (g_lvl[lv-1].ix[2*k]),
                    .hi_ix (g_lvl[lv-1].ix[2*k+1]),
                    .lo_m  (g_lvl[lv-1].m[2*k]),
                    .hi_m  (g_lvl[lv-1].m[2*k+1]),
                    .p_o   (p[k]),
                    .ix_o  (ix[k]),
                    .m_o   (m[k])
                );
            end
        end
    end

    always_comb begin
        y_d     = g_lvl[W].ix[0];
        valid_d = g_lvl[W].p[0];
        multi_d = g_lvl[W].m[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder_using_mux_design.sv
// Bench for encoder_using_mux_design: directed vector table, reset sequences,
// exhaustive sweep and random stimulus against a highest-set-bit model.
module tb_encoder_using_mux_design;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] y;
    logic       valid;
    logic       multi;

    int checks;
    int failures;

    encoder_using_mux_design #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .y     (y),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] y;
        logic       valid;
        logic       multi;
    } vec_t;

    // Reference: scan for highest set bit and count ones with plain arithmetic.
    function automatic void model(input logic [7:0] din, output logic [2:0] ey,
                                  output logic ev, output logic em);
        int cnt;
        int hi;
        cnt = 0;
        hi  = 0;
        for (int i = 0; i < 8; i++) begin
            if (din[i]) begin
                cnt = cnt + 1;
                hi  = i;
            end
        end
        ey = 3'(hi);
        ev = (cnt > 0);
        em = (cnt > 1);
    endfunction

    task automatic check(input string name, input logic [2:0] ey,
                         input logic ev, input logic em);
        checks++;
        if (y !== ey || valid !== ev || multi !== em) begin
            failures++;
            $display("FAIL %s: got y=%0d valid=%0b multi=%0b, expected y=%0d valid=%0b multi=%0b",
                     name, y, valid, multi, ey, ev, em);
        end
    endtask

    // Drive d mid-cycle, then sample 1 time unit after the capturing edge.
    task automatic apply(input logic [7:0] din);
        d = din;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0] ey;
        logic       ev, em;
        logic [7:0] r;

        checks   = 0;
        failures = 0;
        d        = 8'hFF;
        rst_n    = 1'b1;

        // Reset with all-ones input: outputs clear without a clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset_async", 3'd0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_hold", 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", 3'd7, 1'b1, 1'b1);

        // Walking one, multi-hot priority, zero vs index-0 alternation.
        vecs.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{8'(1 << i), 3'(i), 1'b1, 1'b0});
        vecs.push_back('{8'h81, 3'd7, 1'b1, 1'b1});
        vecs.push_back('{8'h06, 3'd2, 1'b1, 1'b1});
        vecs.push_back('{8'h18, 3'd4, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'hFE, 3'd7, 1'b1, 1'b1});
        vecs.push_back('{8'h03, 3'd1, 1'b1, 1'b1});
        foreach (vecs[i]) begin
            apply(vecs[i].d);
            check($sformatf("vec%0d_d%02h", i, vecs[i].d), vecs[i].y, vecs[i].valid, vecs[i].multi);
        end

        // Outputs hold between edges even if d changes mid-cycle.
        apply(8'h10);
        d = 8'h02;
        #3 check("hold_mid_cycle", 3'd4, 1'b1, 1'b0);

        // Mid-stream reset while y=5, then resume with one-cycle latency.
        apply(8'h08);
        apply(8'h20);
        check("mid_pre_reset", 3'd5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", 3'd0, 1'b0, 1'b0);
        d = 8'h40;
        @(posedge clk); #1;
        check("mid_reset_hold", 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        apply(8'h40);
        check("mid_resume_40", 3'd6, 1'b1, 1'b0);
        apply(8'h80);
        check("mid_resume_80", 3'd7, 1'b1, 1'b0);

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            model(8'(v), ey, ev, em);
            check($sformatf("exh_d%02h", v), ey, ev, em);
        end

        // Random back-to-back stimulus.
        for (int n = 0; n < 200; n++) begin
            r = 8'($urandom_range(0, 255));
            apply(r);
            model(r, ey, ev, em);
            check($sformatf("rnd%0d_d%02h", n, r), ey, ev, em);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_using_mux_design.md
Name: encoder_using_mux_design

Overview:
- 8-to-3 binary encoder whose encode logic is built as a 2:1 mux tree, not an OR-reduction.
- Takes an N-bit input word and outputs the binary index of the set bit.
- Adds flags for a valid (non-zero) input and for a multi-hot input.
- Registered output stage; used as a leaf encoder in request/select datapaths.

Parameters:
- N, 8, input width; power of two, >= 2.
- W, $clog2(N) (3 at default), output index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- d  input  N  input word; one-hot in normal use.
- y  output  W  encoded index of the highest set bit of d (registered).
- valid  output  1  registered; 1 when d was non-zero.
- multi  output  1  registered; 1 when d had more than one bit set.

Behaviour:
- Reset: while rst_n=0, y=0, valid=0, multi=0, asynchronously on assertion.
- First capture after reset is released is at the first rising clk edge with rst_n=1.
- Latency: exactly 1 cycle.
  - d sampled at rising edge k appears on y/valid/multi after edge k.
  - Outputs hold until the next edge.
  - No handshake; a new d is accepted every cycle.
- Encoding: y = index i of the highest set bit of d (priority: MSB wins).
  - One-hot inputs therefore give the exact index: 0x01->0, 0x02->1, 0x04->2, 0x08->3, 0x10->4, 0x20->5, 0x40->6, 0x80->7.
- Zero input: d=0 gives y=0, valid=0, multi=0.
  - y=0 with valid=0 is distinguishable from d=0x01 (y=0, valid=1).
- Multi-hot: y = highest set index and multi=1.
  - Example: 0x81 gives y=7, valid=1, multi=1.
- Mux-tree structure:
  - log2(N) levels of 2:1 muxes; level L merges adjacent pairs of (present, partial index) tuples.
  - Select = "upper half present"; the upper half wins.
  - The new index MSB is the select bit; the lower bits come from the muxed partial indices.
  - The present output of the root is valid.
- multi: computed combinationally as "more than one bit set".
  - At any tree node, both halves present => multi.
  - Node multi flags are OR-ed up the tree.
- X/unknown on d: outputs are not specified; the bench drives only 0/1.
- Reset asserted mid-stream: outputs clear immediately. No pending state survives; there is no other state.

Decomposition:
- Shared package enc_pkg:
  - parameter N_DEFAULT = 8.
  - function clog2 helper (if the tool lacks $clog2).
  - typedef enc_idx_t = logic [2:0] for the default width.
- One sub-module: enc_mux_node.
  - Inputs: lo/hi present, lo/hi index, lo/hi multi.
  - Outputs: merged present, index (one bit wider), multi.
  - Generated N-1 times in a generate tree.
- Top: generate tree, combinational root result, output register with async active-low reset.

Test Plan:
- Reset: rst_n=0 with d=0xFF -> y=0, valid=0, multi=0 immediately; hold 2 cycles, release, next edge -> y=7, valid=1, multi=1.
- Walking one: d=0x00,0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80, one per cycle -> y one cycle later = 0,0,1,2,3,4,5,6,7; valid = 0,1,1,1,1,1,1,1,1; multi=0 throughout.
- Multi-hot priority: d=0x81 -> y=7, multi=1; d=0x06 -> y=2, multi=1; d=0x18 -> y=4, multi=1; valid=1 each.
- Zero vs index 0: d=0x00 -> y=0, valid=0; d=0x01 -> y=0, valid=1; back-to-back alternation toggles valid each cycle with y constant 0.
- Mid-stream reset: walking one running, assert rst_n asynchronously between edges while y=5 -> outputs clear at once; release -> resumes with 1-cycle latency.
- Exhaustive: all 256 d values vs reference model -> y = highest set index; valid = |d; multi = popcount(d)>1.
